// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, taken-branch squash and
// operand forwarding selection, plus saturating bubble/flush counters.
module id_hazard_ctrl (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  ID_RA,
    input  logic [4:0]  ID_RB,
    input  logic        ID_USES_RA,
    input  logic        ID_USES_RB,
    input  logic [4:0]  EX_RD,
    input  logic        EX_RF_LE,
    input  logic        EX_L,
    input  logic [4:0]  MEM_RD,
    input  logic        MEM_RF_LE,
    input  logic [4:0]  WB_RD,
    input  logic        WB_RF_LE,
    input  logic        BR_TAKEN,
    output logic        PC_LE,
    output logic        IF_ID_LE,
    output logic        IF_ID_FLUSH,
    output logic        CU_NOP,
    output logic [1:0]  FWD_A,
    output logic [1:0]  FWD_B,
    output logic [15:0] STALL_CNT,
    output logic [15:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        BRFLUSH = 2'd2
    } state_t;

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_EX  = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;
    localparam logic [1:0] SRC_WB  = 2'b11;

    state_t      r_state;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_lu_a;
    logic        w_lu_b;
    logic        w_lu;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // A load in EX cannot feed ID from EX; that case is resolved by the stall.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rx,
        input logic       uses,
        input logic [4:0] ex_rd,
        input logic       ex_le,
        input logic       ex_l,
        input logic [4:0] mem_rd,
        input logic       mem_le,
        input logic [4:0] wb_rd,
        input logic       wb_le
    );
        logic [1:0] sel;
        sel = SRC_RF;
        if (uses && rx != 5'd0) begin
            if (ex_le && !ex_l && ex_rd == rx)
                sel = SRC_EX;
            else if (mem_le && mem_rd == rx)
                sel = SRC_MEM;
            else if (wb_le && wb_rd == rx)
                sel = SRC_WB;
        end
        return sel;
    endfunction

    assign w_lu_a = ID_USES_RA && (EX_RD == ID_RA);
    assign w_lu_b = ID_USES_RB && (EX_RD == ID_RB);
    assign w_lu   = EX_L && EX_RF_LE && (EX_RD != 5'd0) && (w_lu_a || w_lu_b);

    always_comb begin
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_FLUSH = 1'b0;
        CU_NOP      = 1'b0;
        FWD_A       = SRC_RF;
        FWD_B       = SRC_RF;
        if (Reset) begin
            PC_LE       = 1'b0;
            IF_ID_LE    = 1'b0;
            IF_ID_FLUSH = 1'b1;
            CU_NOP      = 1'b1;
        end else begin
            FWD_A = fwd_sel(ID_RA, ID_USES_RA, EX_RD, EX_RF_LE, EX_L,
                            MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
            FWD_B = fwd_sel(ID_RB, ID_USES_RB, EX_RD, EX_RF_LE, EX_L,
                            MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
            case (r_state)
                RUN: begin
                    // Branch wins over load-use; the delay-slot instruction in ID proceeds.
                    if (BR_TAKEN) begin
                        IF_ID_FLUSH = 1'b1;
                    end else if (w_lu) begin
                        PC_LE    = 1'b0;
                        IF_ID_LE = 1'b0;
                        CU_NOP   = 1'b1;
                    end
                end
                LDSTALL: begin
                    IF_ID_FLUSH = BR_TAKEN;
                end
                BRFLUSH: begin
                    CU_NOP      = 1'b1;
                    IF_ID_FLUSH = BR_TAKEN;
                end
                default: begin
                    PC_LE    = 1'b1;
                    IF_ID_LE = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (CU_NOP)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (BR_TAKEN)
                r_flush_cnt <= sat_inc(r_flush_cnt);
            case (r_state)
                RUN: begin
                    if (BR_TAKEN)
                        r_state <= BRFLUSH;
                    else if (w_lu)
                        r_state <= LDSTALL;
                    else
                        r_state <= RUN;
                end
                LDSTALL, BRFLUSH: begin
                    r_state <= BR_TAKEN ? BRFLUSH : RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: stalls, branches, forwarding, counters, reset.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_RA, ID_RB;
    logic        ID_USES_RA, ID_USES_RB;
    logic [4:0]  EX_RD;
    logic        EX_RF_LE, EX_L;
    logic [4:0]  MEM_RD;
    logic        MEM_RF_LE;
    logic [4:0]  WB_RD;
    logic        WB_RF_LE;
    logic        BR_TAKEN;
    logic        PC_LE, IF_ID_LE, IF_ID_FLUSH, CU_NOP;
    logic [1:0]  FWD_A, FWD_B;
    logic [15:0] STALL_CNT, FLUSH_CNT;

    int checks = 0;
    int passed = 0;

    id_hazard_ctrl dut (
        .clk(clk), .Reset(Reset),
        .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_USES_RA(ID_USES_RA), .ID_USES_RB(ID_USES_RB),
        .EX_RD(EX_RD), .EX_RF_LE(EX_RF_LE), .EX_L(EX_L),
        .MEM_RD(MEM_RD), .MEM_RF_LE(MEM_RF_LE),
        .WB_RD(WB_RD), .WB_RF_LE(WB_RF_LE),
        .BR_TAKEN(BR_TAKEN),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_FLUSH(IF_ID_FLUSH), .CU_NOP(CU_NOP),
        .FWD_A(FWD_A), .FWD_B(FWD_B),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 clk = ~clk;

    // Control vector order: {PC_LE, IF_ID_LE, IF_ID_FLUSH, CU_NOP}
    wire [3:0] ctl = {PC_LE, IF_ID_LE, IF_ID_FLUSH, CU_NOP};

    task automatic clear_inputs();
        ID_RA = 0; ID_RB = 0; ID_USES_RA = 0; ID_USES_RB = 0;
        EX_RD = 0; EX_RF_LE = 0; EX_L = 0;
        MEM_RD = 0; MEM_RF_LE = 0; WB_RD = 0; WB_RF_LE = 0;
        BR_TAKEN = 0;
    endtask

    // Advance one edge, leaving time to drive inputs before the next check.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1;
        step();
        step();
        Reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1;
        ID_RA = 3; ID_USES_RA = 1; MEM_RD = 3; MEM_RF_LE = 1;
        ID_RB = 4; ID_USES_RB = 1; WB_RD = 4; WB_RF_LE = 1;
        BR_TAKEN = 1;
        step(); settle();
        checks++; if (ctl !== 4'b0011) $display("FAIL reset_ctl got %b exp %b", ctl, 4'b0011); else passed++;
        checks++; if ({FWD_A, FWD_B} !== 4'b0000) $display("FAIL reset_fwd got %b exp %b", {FWD_A, FWD_B}, 4'b0000); else passed++;
        checks++; if ({STALL_CNT, FLUSH_CNT} !== 32'd0) $display("FAIL reset_cnt got %h exp %h", {STALL_CNT, FLUSH_CNT}, 32'd0); else passed++;
        clear_inputs();
        Reset = 0;
        settle();
        checks++; if (ctl !== 4'b1100) $display("FAIL reset_release_ctl got %b exp %b", ctl, 4'b1100); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        EX_L = 1; EX_RF_LE = 1; EX_RD = 5; ID_RA = 5; ID_USES_RA = 1;
        settle();
        checks++; if (ctl !== 4'b0001) $display("FAIL lu_stall_ctl got %b exp %b", ctl, 4'b0001); else passed++;
        checks++; if (FWD_A !== 2'b00) $display("FAIL lu_no_ex_fwd got %b exp %b", FWD_A, 2'b00); else passed++;
        step();
        EX_L = 0; EX_RF_LE = 0; EX_RD = 0; MEM_RD = 5; MEM_RF_LE = 1;
        settle();
        checks++; if (ctl !== 4'b1100) $display("FAIL lu_ldstall_ctl got %b exp %b", ctl, 4'b1100); else passed++;
        checks++; if (FWD_A !== 2'b10) $display("FAIL lu_fwd_mem got %b exp %b", FWD_A, 2'b10); else passed++;
        checks++; if (STALL_CNT !== 16'd1) $display("FAIL lu_stall_cnt got %0d exp %0d", STALL_CNT, 1); else passed++;
        step(); clear_inputs(); settle();
        checks++; if (STALL_CNT !== 16'd1) $display("FAIL lu_single_bubble got %0d exp %0d", STALL_CNT, 1); else passed++;
        checks++; if (ctl !== 4'b1100) $display("FAIL lu_back_run got %b exp %b", ctl, 4'b1100); else passed++;
    endtask

    task automatic test_forward_priority();
        do_reset();
        EX_RD = 7; MEM_RD = 7; WB_RD = 7; EX_RF_LE = 1; MEM_RF_LE = 1; WB_RF_LE = 1;
        ID_RB = 7; ID_USES_RB = 1; ID_RA = 7; ID_USES_RA = 0;
        settle();
        checks++; if (FWD_B !== 2'b01) $display("FAIL fwd_ex got %b exp %b", FWD_B, 2'b01); else passed++;
        checks++; if (FWD_A !== 2'b00) $display("FAIL fwd_unused_a got %b exp %b", FWD_A, 2'b00); else passed++;
        EX_RF_LE = 0; settle();
        checks++; if (FWD_B !== 2'b10) $display("FAIL fwd_mem got %b exp %b", FWD_B, 2'b10); else passed++;
        MEM_RF_LE = 0; settle();
        checks++; if (FWD_B !== 2'b11) $display("FAIL fwd_wb got %b exp %b", FWD_B, 2'b11); else passed++;
        ID_RB = 0; EX_RD = 0; MEM_RD = 0; WB_RD = 0; EX_RF_LE = 1; MEM_RF_LE = 1; settle();
        checks++; if (FWD_B !== 2'b00) $display("FAIL fwd_r0 got %b exp %b", FWD_B, 2'b00); else passed++;
        ID_RB = 9; EX_RD = 9; EX_L = 1; EX_RF_LE = 1; MEM_RD = 3; WB_RD = 9; WB_RF_LE = 1; ID_USES_RA = 1; ID_RA = 3;
        settle();
        checks++; if ({FWD_A, FWD_B} !== 4'b1011) $display("FAIL fwd_mixed got %b exp %b", {FWD_A, FWD_B}, 4'b1011); else passed++;
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        BR_TAKEN = 1; settle();
        checks++; if (ctl !== 4'b1110) $display("FAIL br_run_ctl got %b exp %b", ctl, 4'b1110); else passed++;
        step(); BR_TAKEN = 0; settle();
        checks++; if (ctl !== 4'b1101) $display("FAIL br_flush_ctl got %b exp %b", ctl, 4'b1101); else passed++;
        checks++; if (FLUSH_CNT !== 16'd1) $display("FAIL br_flush_cnt got %0d exp %0d", FLUSH_CNT, 1); else passed++;
        step(); settle();
        checks++; if (ctl !== 4'b1100) $display("FAIL br_back_run got %b exp %b", ctl, 4'b1100); else passed++;
        checks++; if ({STALL_CNT, FLUSH_CNT} !== {16'd1, 16'd1}) $display("FAIL br_counts got %h exp %h", {STALL_CNT, FLUSH_CNT}, {16'd1, 16'd1}); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        BR_TAKEN = 1; EX_L = 1; EX_RF_LE = 1; EX_RD = 6; ID_RB = 6; ID_USES_RB = 1;
        settle();
        checks++; if (ctl !== 4'b1110) $display("FAIL sim_ctl got %b exp %b", ctl, 4'b1110); else passed++;
        step(); BR_TAKEN = 0; settle();
        checks++; if (ctl !== 4'b1101) $display("FAIL sim_brflush_not_ldstall got %b exp %b", ctl, 4'b1101); else passed++;
        step(); clear_inputs(); settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== {16'd1, 16'd1}) $display("FAIL sim_counts got %h exp %h", {STALL_CNT, FLUSH_CNT}, {16'd1, 16'd1}); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        EX_L = 1; EX_RF_LE = 1; EX_RD = 2; ID_RA = 2; ID_USES_RA = 1;
        step();
        // Hazard left asserted in LDSTALL must not stall again; branch then flushes.
        BR_TAKEN = 1; settle();
        checks++; if (ctl !== 4'b1110) $display("FAIL b2b_ldstall_br got %b exp %b", ctl, 4'b1110); else passed++;
        step(); settle();
        checks++; if (ctl !== 4'b1111) $display("FAIL b2b_brflush_br got %b exp %b", ctl, 4'b1111); else passed++;
        step(); BR_TAKEN = 0; settle();
        checks++; if (ctl !== 4'b1101) $display("FAIL b2b_brflush_end got %b exp %b", ctl, 4'b1101); else passed++;
        step(); clear_inputs(); settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== {16'd3, 16'd2}) $display("FAIL b2b_counts got %h exp %h", {STALL_CNT, FLUSH_CNT}, {16'd3, 16'd2}); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        EX_L = 1; EX_RF_LE = 1; EX_RD = 5; ID_RA = 5; ID_USES_RA = 1;
        step();
        MEM_RD = 5; MEM_RF_LE = 1; EX_L = 0; EX_RF_LE = 0; EX_RD = 0;
        Reset = 1; settle();
        checks++; if (ctl !== 4'b0011) $display("FAIL rmid_ctl got %b exp %b", ctl, 4'b0011); else passed++;
        checks++; if (FWD_A !== 2'b00) $display("FAIL rmid_fwd got %b exp %b", FWD_A, 2'b00); else passed++;
        step(); settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== 32'd0) $display("FAIL rmid_cnt got %h exp %h", {STALL_CNT, FLUSH_CNT}, 32'd0); else passed++;
        Reset = 0; clear_inputs(); settle();
        checks++; if (ctl !== 4'b1100) $display("FAIL rmid_release got %b exp %b", ctl, 4'b1100); else passed++;
        step(); settle();
        checks++; if (STALL_CNT !== 16'd0) $display("FAIL rmid_no_bubble got %0d exp %0d", STALL_CNT, 0); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        BR_TAKEN = 1;
        for (int i = 0; i < 65540; i++) step();
        settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== 32'hFFFF_FFFF) $display("FAIL sat_counts got %h exp %h", {STALL_CNT, FLUSH_CNT}, 32'hFFFF_FFFF); else passed++;
        step(); settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== 32'hFFFF_FFFF) $display("FAIL sat_hold got %h exp %h", {STALL_CNT, FLUSH_CNT}, 32'hFFFF_FFFF); else passed++;
        BR_TAKEN = 0;
        Reset = 1; step(); settle();
        checks++; if ({STALL_CNT, FLUSH_CNT} !== 32'd0) $display("FAIL sat_reset got %h exp %h", {STALL_CNT, FLUSH_CNT}, 32'd0); else passed++;
        Reset = 0;
    endtask

    initial begin
        clear_inputs();
        Reset = 1;
        test_reset();
        test_load_use();
        test_forward_priority();
        test_branch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
